// File: rtl/multiplier32_iter_pkg.sv
// -----------------------------------------------------------------------------
// multiplier32_iter_pkg
// Shared constants and types for the iterative 32x32 multiplier.
//   MSB_POS__MUL32_INOUT : MSB index of the command/result data words
//   MUL32_CHUNK_WIDTH    : multiplier bits consumed per BUSY step
//   MUL32_NUM_CHUNKS     : BUSY steps for a full 32-bit multiplier
//   Mul32State           : FSM state encoding (Idle, Busy)
// -----------------------------------------------------------------------------
package multiplier32_iter_pkg;

    localparam int MSB_POS__MUL32_INOUT = 31;
    localparam int MUL32_WIDTH          = MSB_POS__MUL32_INOUT + 1;
    localparam int MUL32_CHUNK_WIDTH    = 8;
    localparam int MUL32_NUM_CHUNKS     = 4;
    localparam int MUL32_CNT_WIDTH      = $clog2(MUL32_NUM_CHUNKS);

    typedef enum logic {
        Idle = 1'b0,
        Busy = 1'b1
    } Mul32State;

endpackage

// File: rtl/multiplier32_iter_if.sv
// -----------------------------------------------------------------------------
// mul32_if
// Command/response bundle between the CPU (master) and the multiplier (slave).
//   enable         : master -> slave, command strobe, sampled only in IDLE
//   x, y           : master -> slave, unsigned operands
//   can_accept_cmd : slave -> master, high while the multiplier is IDLE
//   data_ready     : slave -> master, one-cycle strobe, prod valid with it
//   prod           : slave -> master, low 32 bits of x*y, held until next result
// Handshake: a command transfers on a rising edge where enable=1 and
// can_accept_cmd=1; enable at any other edge is dropped, never queued. The
// result has no backpressure: data_ready is a single-cycle pulse.
// -----------------------------------------------------------------------------
interface mul32_if;
    import multiplier32_iter_pkg::*;

    logic                          enable;
    logic [MSB_POS__MUL32_INOUT:0] x;
    logic [MSB_POS__MUL32_INOUT:0] y;
    logic                          can_accept_cmd;
    logic                          data_ready;
    logic [MSB_POS__MUL32_INOUT:0] prod;

    modport master (
        output enable, x, y,
        input  can_accept_cmd, data_ready, prod
    );

    modport slave (
        input  enable, x, y,
        output can_accept_cmd, data_ready, prod
    );

endinterface

// File: rtl/multiplier32_iter_chunk_step.sv
// -----------------------------------------------------------------------------
// mul32_chunk_step
// One combinational shift-and-add step: folds the low chunk of the multiplier
// into the accumulator and shifts both operands for the next step.
//   acc_i / acc_o       : running partial product (mod 2^32)
//   mcand_i / mcand_o   : multiplicand, shifted left one chunk per step
//   mplier_i / mplier_o : multiplier, shifted right one chunk per step
// -----------------------------------------------------------------------------
module mul32_chunk_step
    import multiplier32_iter_pkg::*;
(
    input  logic [MUL32_WIDTH-1:0] acc_i,
    input  logic [MUL32_WIDTH-1:0] mcand_i,
    input  logic [MUL32_WIDTH-1:0] mplier_i,
    output logic [MUL32_WIDTH-1:0] acc_o,
    output logic [MUL32_WIDTH-1:0] mcand_o,
    output logic [MUL32_WIDTH-1:0] mplier_o
);

    logic [MUL32_CHUNK_WIDTH-1:0] chunk;
    logic [MUL32_WIDTH-1:0]       partial;

    assign chunk = mplier_i[MUL32_CHUNK_WIDTH-1:0];

    // 32-bit context keeps only the low word of the 32x8 product, which is all
    // the final result needs.
    assign partial  = mcand_i * MUL32_WIDTH'(chunk);
    assign acc_o    = acc_i + partial;
    assign mcand_o  = mcand_i << MUL32_CHUNK_WIDTH;
    assign mplier_o = mplier_i >> MUL32_CHUNK_WIDTH;

endmodule

// File: rtl/multiplier32_iter.sv
// -----------------------------------------------------------------------------
// multiplier32_iter
// Iterative 32x32 -> 32 multiplier, 8 multiplier bits per cycle.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   mul_bus : mul32_if.slave command/response bundle
//   state_o : current FSM state (debug visibility)
// Accept at edge E, BUSY steps at E+1..E+4, data_ready in the cycle after the
// last step. Optional macro MUL32_EARLY_EXIT_EN: finish as soon as the
// remaining multiplier bits are all zero (latency 1..4).
// -----------------------------------------------------------------------------
module multiplier32_iter
    import multiplier32_iter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mul32_if.slave    mul_bus,
    output Mul32State state_o
);

    Mul32State                  state_q;
    logic [MUL32_WIDTH-1:0]     acc_q;
    logic [MUL32_WIDTH-1:0]     mcand_q;
    logic [MUL32_WIDTH-1:0]     mplier_q;
    logic [MUL32_WIDTH-1:0]     prod_q;
    logic [MUL32_CNT_WIDTH-1:0] cnt_q;
    logic                       data_ready_q;

    logic [MUL32_WIDTH-1:0]     acc_d;
    logic [MUL32_WIDTH-1:0]     mcand_d;
    logic [MUL32_WIDTH-1:0]     mplier_d;
    logic                       last_step_d;

    mul32_chunk_step u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_d),
        .mcand_o  (mcand_d),
        .mplier_o (mplier_d)
    );

    // Decides whether the step taken at the coming edge is the final one.
    always_comb begin
        last_step_d = (cnt_q == MUL32_CNT_WIDTH'(MUL32_NUM_CHUNKS - 1));
`ifdef MUL32_EARLY_EXIT_EN
        // No multiplier bits left means every further partial product is zero.
        if (mplier_d == '0) begin
            last_step_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= Idle;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            prod_q       <= '0;
            cnt_q        <= '0;
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            case (state_q)
                Idle: begin
                    if (mul_bus.enable) begin
                        mcand_q  <= mul_bus.x;
                        mplier_q <= mul_bus.y;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= Busy;
                    end
                end
                Busy: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + MUL32_CNT_WIDTH'(1);
                    if (last_step_d) begin
                        prod_q       <= acc_d;
                        data_ready_q <= 1'b1;
                        state_q      <= Idle;
                    end
                end
                default: begin
                    state_q <= Idle;
                end
            endcase
        end
    end

    assign mul_bus.can_accept_cmd = (state_q == Idle);
    assign mul_bus.data_ready     = data_ready_q;
    assign mul_bus.prod           = prod_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_multiplier32_iter.sv
// -----------------------------------------------------------------------------
// tb_multiplier32_iter
// Directed and randomized checks of multiplier32_iter against a plain
// arithmetic reference (x*y truncated to 32 bits). Completion is detected via
// data_ready; latency is only compared against the mode-dependent expectation.
// Build with +define+MUL32_EARLY_EXIT_EN to exercise the early-exit variant.
// -----------------------------------------------------------------------------
module tb_multiplier32_iter;
    import multiplier32_iter_pkg::*;

    logic      clk;
    logic      rst;
    Mul32State dbg_state;

    mul32_if bus ();

    multiplier32_iter dut (
        .clk     (clk),
        .rst     (rst),
        .mul_bus (bus.slave),
        .state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: low word of the unsigned product.
    function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // Expected cycles from accept edge to the edge that raises data_ready.
    function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL32_EARLY_EXIT_EN
        if (b < 32'h0000_0100) return 1;
        if (b < 32'h0001_0000) return 2;
        if (b < 32'h0100_0000) return 3;
        return 4;
`else
        return 4;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge with the DUT idle; returns #1 after edge E.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        check("cac_before_issue", {31'd0, bus.can_accept_cmd}, 32'd1);
        bus.enable = 1'b1;
        bus.x      = a;
        bus.y      = b;
        exp_q.push_back(ref_prod(a, b));
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
    endtask

    // Waits (bounded) for data_ready and checks result, latency and handshake.
    task automatic wait_done(input logic [31:0] b);
        int          cyc;
        logic [31:0] exp;
        cyc = 0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        while (!bus.data_ready && cyc < 8) begin
            check("cac_busy", {31'd0, bus.can_accept_cmd}, 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", {31'd0, bus.data_ready}, 32'd1);
        check("latency", cyc, exp_latency(b));
        check("prod", bus.prod, exp);
        check("cac_done", {31'd0, bus.can_accept_cmd}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] held;
        issue(a, b);
        wait_done(b);
        held = bus.prod;
        @(posedge clk);
        #1;
        check("dr_single_cycle", {31'd0, bus.data_ready}, 32'd0);
        check("prod_hold", bus.prod, held);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] prev;
        int          nbytes;

        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.x      = '0;
        bus.y      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cac", {31'd0, bus.can_accept_cmd}, 32'd1);
        check("rst_dr", {31'd0, bus.data_ready}, 32'd0);
        check("rst_prod", bus.prod, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle with enable low must stay idle.
        repeat (3) @(posedge clk);
        #1;
        check("idle_cac", {31'd0, bus.can_accept_cmd}, 32'd1);
        check("idle_dr", {31'd0, bus.data_ready}, 32'd0);

        // Directed products.
        run_op(32'd3, 32'd5);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h1234_5678, 32'h9ABC_DEF0);
        run_op(32'd2, 32'h0000_00FF);
        run_op(32'h1234_5678, 32'd0);
        run_op(32'd5, 32'h0100_0000);
        run_op(32'h0000_0101, 32'h0000_ABCD);
        run_op(32'h8000_0001, 32'h00FF_0003);

        // Commands while busy are dropped.
        issue(32'd7, 32'd6);
        bus.enable = 1'b1;
        bus.x      = 32'd2;
        bus.y      = 32'd2;
        wait_done(32'd6);
        bus.enable = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.data_ready) pulses++;
        end
        check("busy_ignore_pulses", pulses, 32'd0);
        check("busy_ignore_prod", bus.prod, 32'd42);
        run_op(32'd2, 32'd2);

        // Back-to-back: new command in the data_ready cycle.
        issue(32'h0000_1234, 32'h0000_5678);
        wait_done(32'h0000_5678);
        prev       = bus.prod;
        bus.enable = 1'b1;
        bus.x      = 32'd10;
        bus.y      = 32'd10;
        exp_q.push_back(ref_prod(32'd10, 32'd10));
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        check("b2b_dr_drop", {31'd0, bus.data_ready}, 32'd0);
        check("b2b_cac", {31'd0, bus.can_accept_cmd}, 32'd0);
        check("b2b_prev_hold", bus.prod, prev);
        wait_done(32'd10);
        @(posedge clk);
        #1;

        // Randomized operands; multiplier width varied to cover every exit point.
        for (int i = 0; i < 30; i++) begin
            ra     = $urandom;
            rb     = $urandom;
            nbytes = $urandom_range(0, 4);
            case (nbytes)
                0:       rb = 32'd0;
                1:       rb = rb & 32'h0000_00FF;
                2:       rb = rb & 32'h0000_FFFF;
                3:       rb = rb & 32'h00FF_FFFF;
                default: rb = rb;
            endcase
            run_op(ra, rb);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset mid-operation aborts without a result.
        issue(32'd9, 32'h0900_0009);
        void'(exp_q.pop_front());
        pulses = 0;
        @(posedge clk);
        #1;
        if (bus.data_ready) pulses++;
        @(posedge clk);
        #1;
        if (bus.data_ready) pulses++;
        rst = 1'b1;
        #1;
        check("rst_mid_prod", bus.prod, 32'd0);
        check("rst_mid_cac", {31'd0, bus.can_accept_cmd}, 32'd1);
        check("rst_mid_dr", {31'd0, bus.data_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.data_ready) pulses++;
        end
        check("rst_mid_pulses", pulses, 32'd0);
        check("rst_mid_prod_after", bus.prod, 32'd0);

        // Recovery after reset.
        run_op(32'd9, 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
